// File: rtl/kv10_pkg.sv
// Shared types for the KV10 memory-side blocks.
//   addr_t      : 18-bit memory address, bit 0 is the MSB (PDP-10 numbering)
//   word_t      : 36-bit memory word, bit 0 is the MSB
//   arb_state_t : memory arbiter sequencing states
package kv10_pkg;

    localparam int ADDR_W = 18;
    localparam int WORD_W = 36;

    typedef logic [0:ADDR_W-1] addr_t;
    typedef logic [0:WORD_W-1] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/kv10_rr_pick.sv
// Combinational requester picker, shared by the memory and I/O bus arbiters.
//   active    : one bit per requester wanting service
//   ptr       : round-robin start index (ignored when fixed_pri is set)
//   fixed_pri : 1 = lowest active index wins, 0 = first active at/after ptr
//   winner    : index of the chosen requester (0 when nothing is active)
//   valid     : at least one requester is active
module kv10_rr_pick #(
    parameter  int NREQ  = 2,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  active,
    input  logic [IDX_W-1:0] ptr,
    input  logic             fixed_pri,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    always_comb begin
        int base;
        int idx;
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        base   = fixed_pri ? 0 : int'(ptr);
        // Walk the requesters starting at base, wrapping NREQ-1 -> 0;
        // the first active one encountered wins.
        for (int k = 0; k < NREQ; k++) begin
            idx = (base + k) % NREQ;
            if (!valid && active[idx]) begin
                valid  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/kv10_mem_arbiter.sv
// KV10 memory bus arbiter: shares the single memory master port among NREQ
// requesters, holds the bus strobe until the slave answers (read ack, write
// ack or page fail) and reports the outcome to the winner as a one-cycle
// one-hot pulse.  A slave that never answers produces an NXM pulse after
// TIMEOUT cycles.
//
// Ports
//   clk, reset          : system clock, synchronous active-high reset
//   req_read/req_write  : per-requester level requests, held until completion
//   req_addr/req_wdata  : per-requester address and write data
//   req_rdata           : last successfully read word
//   req_ack/pf/nxm      : one-hot completion pulses (ok / page fail / timeout)
//   mem_*               : memory bus master side (mem_reset mirrors reset)
//   busy                : arbiter not in IDLE
//   grant_id            : current or most recent grantee
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no transaction; pick a winner from the active requests
// WAIT  | strobe driven, waiting for slave response or timeout
// DONE  | completion pulse cycle; advance round-robin pointer
module kv10_mem_arbiter
    import kv10_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int TIMEOUT   = 64,
    parameter int FIXED_PRI = 0
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic [NREQ-1:0]           req_read,
    input  logic [NREQ-1:0]           req_write,
    input  addr_t [NREQ-1:0]          req_addr,
    input  word_t [NREQ-1:0]          req_wdata,
    output word_t                     req_rdata,
    output logic [NREQ-1:0]           req_ack,
    output logic [NREQ-1:0]           req_pf,
    output logic [NREQ-1:0]           req_nxm,

    output logic                      mem_reset,
    output addr_t                     mem_address,
    output word_t                     mem_write_data,
    output logic                      mem_read,
    output logic                      mem_write,
    input  word_t                     mem_read_data,
    input  logic                      mem_read_ack,
    input  logic                      mem_write_ack,
    input  logic                      mem_page_fail,

    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   grant_id
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [NREQ-1:0]  ONE_HOT0 = NREQ'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

    arb_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [IDX_W-1:0] ptr, ptr_n;
    logic [IDX_W-1:0] grant_id_n;
    addr_t            mem_address_n;
    word_t            mem_write_data_n;
    logic             mem_read_n, mem_write_n;
    logic [NREQ-1:0]  req_ack_n, req_pf_n, req_nxm_n;
    word_t            req_rdata_n;
    logic             busy_n;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic             ack_match;

    assign mem_reset = reset;

    kv10_rr_pick #(
        .NREQ      (NREQ)
    ) u_pick (
        .active    (req_read | req_write),
        .ptr       (ptr),
        .fixed_pri (FIXED_PRI != 0),
        .winner    (pick_idx),
        .valid     (pick_valid)
    );

    // Only the ack matching the strobe we are driving counts.
    assign ack_match = (mem_read & mem_read_ack) | (mem_write & mem_write_ack);

    always_comb begin
        state_n          = state;
        cnt_n            = cnt;
        ptr_n            = ptr;
        grant_id_n       = grant_id;
        mem_address_n    = mem_address;
        mem_write_data_n = mem_write_data;
        mem_read_n       = mem_read;
        mem_write_n      = mem_write;
        req_ack_n        = '0;
        req_pf_n         = '0;
        req_nxm_n        = '0;
        req_rdata_n      = req_rdata;

        case (state)
            IDLE: begin
                if (pick_valid) begin
                    grant_id_n       = pick_idx;
                    mem_address_n    = req_addr[pick_idx];
                    mem_write_data_n = req_wdata[pick_idx];
                    // Read wins when a requester raises both.
                    mem_read_n       = req_read[pick_idx];
                    mem_write_n      = req_write[pick_idx] & ~req_read[pick_idx];
                    // Down-counter reaching zero marks the last waiting cycle.
                    cnt_n            = CNT_LOAD;
                    state_n          = WAIT;
                end
            end

            WAIT: begin
                if (mem_page_fail) begin
                    req_pf_n    = ONE_HOT0 << grant_id;
                    mem_read_n  = 1'b0;
                    mem_write_n = 1'b0;
                    state_n     = DONE;
                end else if (ack_match) begin
                    req_ack_n   = ONE_HOT0 << grant_id;
                    if (mem_read) begin
                        req_rdata_n = mem_read_data;
                    end
                    mem_read_n  = 1'b0;
                    mem_write_n = 1'b0;
                    state_n     = DONE;
                end else if (cnt == '0) begin
                    req_nxm_n   = ONE_HOT0 << grant_id;
                    mem_read_n  = 1'b0;
                    mem_write_n = 1'b0;
                    state_n     = DONE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end

            DONE: begin
                ptr_n   = (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;
                state_n = IDLE;
            end

            default: begin
                mem_read_n  = 1'b0;
                mem_write_n = 1'b0;
                state_n     = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            ptr            <= '0;
            grant_id       <= '0;
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            req_ack        <= '0;
            req_pf         <= '0;
            req_nxm        <= '0;
            req_rdata      <= '0;
            busy           <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            ptr            <= ptr_n;
            grant_id       <= grant_id_n;
            mem_address    <= mem_address_n;
            mem_write_data <= mem_write_data_n;
            mem_read       <= mem_read_n;
            mem_write      <= mem_write_n;
            req_ack        <= req_ack_n;
            req_pf         <= req_pf_n;
            req_nxm        <= req_nxm_n;
            req_rdata      <= req_rdata_n;
            busy           <= busy_n;
        end
    end

endmodule

// File: tb/tb_kv10_mem_arbiter.sv
module tb_kv10_mem_arbiter;
    import kv10_pkg::*;

    localparam int NREQ    = 3;
    localparam int TIMEOUT = 8;
    localparam int IDX_W   = $clog2(NREQ);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset;
    logic [NREQ-1:0]       req_read, req_write;
    addr_t [NREQ-1:0]      req_addr;
    word_t [NREQ-1:0]      req_wdata;
    word_t                 mem_read_data;
    logic                  mem_read_ack, mem_write_ack, mem_page_fail;

    word_t             rdata_0, rdata_1, mwdata_0, mwdata_1;
    addr_t             maddr_0, maddr_1;
    logic [NREQ-1:0]   ack_0, ack_1, pf_0, pf_1, nxm_0, nxm_1;
    logic              mrst_0, mrst_1, mrd_0, mrd_1, mwr_0, mwr_1, busy_0, busy_1;
    logic [IDX_W-1:0]  gid_0, gid_1;

    kv10_mem_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .FIXED_PRI(0)) dut_rr (
        .clk(clk), .reset(reset),
        .req_read(req_read), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rdata(rdata_0), .req_ack(ack_0), .req_pf(pf_0), .req_nxm(nxm_0),
        .mem_reset(mrst_0), .mem_address(maddr_0), .mem_write_data(mwdata_0),
        .mem_read(mrd_0), .mem_write(mwr_0), .mem_read_data(mem_read_data),
        .mem_read_ack(mem_read_ack), .mem_write_ack(mem_write_ack), .mem_page_fail(mem_page_fail),
        .busy(busy_0), .grant_id(gid_0)
    );

    kv10_mem_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .FIXED_PRI(1)) dut_fp (
        .clk(clk), .reset(reset),
        .req_read(req_read), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rdata(rdata_1), .req_ack(ack_1), .req_pf(pf_1), .req_nxm(nxm_1),
        .mem_reset(mrst_1), .mem_address(maddr_1), .mem_write_data(mwdata_1),
        .mem_read(mrd_1), .mem_write(mwr_1), .mem_read_data(mem_read_data),
        .mem_read_ack(mem_read_ack), .mem_write_ack(mem_write_ack), .mem_page_fail(mem_page_fail),
        .busy(busy_1), .grant_id(gid_1)
    );

    // Observe whichever instance the current phase is checking.
    bit sel = 1'b0;
    word_t            o_rdata, o_mwdata;
    addr_t            o_maddr;
    logic [NREQ-1:0]  o_ack, o_pf, o_nxm;
    logic             o_mrst, o_mrd, o_mwr, o_busy;
    logic [IDX_W-1:0] o_gid;
    assign o_rdata  = sel ? rdata_1  : rdata_0;
    assign o_mwdata = sel ? mwdata_1 : mwdata_0;
    assign o_maddr  = sel ? maddr_1  : maddr_0;
    assign o_ack    = sel ? ack_1    : ack_0;
    assign o_pf     = sel ? pf_1     : pf_0;
    assign o_nxm    = sel ? nxm_1    : nxm_0;
    assign o_mrst   = sel ? mrst_1   : mrst_0;
    assign o_mrd    = sel ? mrd_1    : mrd_0;
    assign o_mwr    = sel ? mwr_1    : mwr_0;
    assign o_busy   = sel ? busy_1   : busy_0;
    assign o_gid    = sel ? gid_1    : gid_0;

    int n_checks = 0;
    int n_err    = 0;

    // Transaction-level reference model.
    bit    fixed_m;
    int    ptr_m;
    word_t exp_rdata;
    bit    pend   [NREQ];
    bit    op_rd  [NREQ];
    addr_t m_addr [NREQ];
    word_t m_data [NREQ];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic word_t rand_word();
        word_t v;
        v = {4'($urandom_range(15)), 32'($urandom())};
        return v;
    endfunction

    function automatic int model_pick();
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = fixed_m ? k : (ptr_m + k) % NREQ;
            if (pend[i]) return i;
        end
        return -1;
    endfunction

    // kind: 0 = read only, 1 = write only, 2 = both (read wins)
    task automatic set_req(input int i, input int kind, input addr_t a, input word_t d);
        pend[i]      = 1'b1;
        op_rd[i]     = (kind != 1);
        m_addr[i]    = a;
        m_data[i]    = d;
        req_read[i]  = (kind != 1);
        req_write[i] = (kind != 0);
        req_addr[i]  = a;
        req_wdata[i] = d;
    endtask

    task automatic drop_req(input int i);
        pend[i]      = 1'b0;
        req_read[i]  = 1'b0;
        req_write[i] = 1'b0;
    endtask

    task automatic slave_quiet();
        mem_read_ack  = 1'b0;
        mem_write_ack = 1'b0;
        mem_page_fail = 1'b0;
        mem_read_data = '0;
    endtask

    task automatic slave_noise();
        mem_read_ack  = 1'($urandom_range(1));
        mem_write_ack = 1'($urandom_range(1));
        mem_page_fail = 1'($urandom_range(1));
        mem_read_data = rand_word();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < NREQ; i++) drop_req(i);
        slave_quiet();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_reset", 64'(o_mrst), 64'(1));
        chk("rst_busy", 64'(o_busy), 64'(0));
        chk("rst_strobes", 64'({o_mrd, o_mwr}), 64'(0));
        chk("rst_pulses", 64'({o_ack, o_pf, o_nxm}), 64'(0));
        chk("rst_addr", 64'(o_maddr), 64'(0));
        chk("rst_wdata", 64'(o_mwdata), 64'(0));
        chk("rst_rdata", 64'(o_rdata), 64'(0));
        chk("rst_grant", 64'(o_gid), 64'(0));
        reset     = 1'b0;
        ptr_m     = 0;
        exp_rdata = '0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_release_mem_reset", 64'(o_mrst), 64'(0));
        chk("rst_release_busy", 64'(o_busy), 64'(0));
    endtask

    // One arbitration round, entered and left at the negedge of an IDLE cycle.
    // resp: -1 random, 0 ack, 1 page fail, 2 page fail + ack, 3 no answer.
    task automatic do_round(input logic [NREQ-1:0] new_mask, input int pct_new,
                            input int resp_in, input int lat_in,
                            input bit rd_fixed, input word_t rd_val);
        int w, resp, lat, resp_cyc, r;
        bit is_rd;
        logic [NREQ-1:0] oh;
        for (int i = 0; i < NREQ; i++)
            if (new_mask[i] && !pend[i] && int'($urandom_range(99)) < pct_new)
                set_req(i, int'($urandom_range(2)), addr_t'($urandom()), rand_word());
        if (model_pick() < 0)
            set_req(int'($urandom_range(NREQ-1)), int'($urandom_range(2)),
                    addr_t'($urandom()), rand_word());
        w     = model_pick();
        is_rd = op_rd[w];
        oh    = NREQ'(1) << w;
        if (resp_in >= 0) resp = resp_in;
        else begin
            r    = int'($urandom_range(9));
            resp = (r < 6) ? 0 : (r == 6) ? 1 : (r == 7) ? 2 : 3;
        end
        lat      = (lat_in >= 0) ? lat_in : int'($urandom_range(3));
        resp_cyc = (resp == 3) ? TIMEOUT : lat + 1;

        @(posedge clk);
        @(negedge clk);
        chk("grant_id", 64'(o_gid), 64'(w));
        chk("busy_wait", 64'(o_busy), 64'(1));
        chk("strobe_kind", 64'({o_mrd, o_mwr}), 64'({is_rd, ~is_rd}));
        chk("mem_address", 64'(o_maddr), 64'(m_addr[w]));
        chk("mem_write_data", 64'(o_mwdata), 64'(m_data[w]));

        for (int k = 1; k <= resp_cyc; k++) begin
            if (k > 1) begin
                chk("strobe_hold", 64'({o_mrd, o_mwr}), 64'({is_rd, ~is_rd}));
                chk("addr_hold", 64'(o_maddr), 64'(m_addr[w]));
                chk("no_pulse_wait", 64'({o_ack, o_pf, o_nxm}), 64'(0));
            end
            if (k == 1 && $urandom_range(7) == 0) begin
                req_read[w]  = 1'b0;
                req_write[w] = 1'b0;
            end
            mem_read_data = (rd_fixed && k == resp_cyc) ? rd_val : rand_word();
            mem_read_ack  = 1'b0;
            mem_write_ack = 1'b0;
            mem_page_fail = 1'b0;
            if (k == resp_cyc && resp != 3) begin
                if (resp != 1) begin
                    if (is_rd) mem_read_ack = 1'b1;
                    else       mem_write_ack = 1'b1;
                end
                if (resp >= 1) mem_page_fail = 1'b1;
            end else begin
                if (is_rd) mem_write_ack = 1'($urandom_range(1));
                else       mem_read_ack  = 1'($urandom_range(1));
            end
            if (k == resp_cyc && resp == 0 && is_rd) exp_rdata = mem_read_data;
            @(posedge clk);
            @(negedge clk);
        end

        chk("done_ack", 64'(o_ack), 64'((resp == 0) ? oh : '0));
        chk("done_pf", 64'(o_pf), 64'((resp == 1 || resp == 2) ? oh : '0));
        chk("done_nxm", 64'(o_nxm), 64'((resp == 3) ? oh : '0));
        chk("done_strobes", 64'({o_mrd, o_mwr}), 64'(0));
        chk("done_busy", 64'(o_busy), 64'(1));
        chk("done_rdata", 64'(o_rdata), 64'(exp_rdata));
        drop_req(w);
        ptr_m = (w + 1) % NREQ;
        slave_noise();
        @(posedge clk);
        @(negedge clk);
        chk("idle_busy", 64'(o_busy), 64'(0));
        chk("idle_pulses", 64'({o_ack, o_pf, o_nxm}), 64'(0));
        chk("idle_strobes", 64'({o_mrd, o_mwr}), 64'(0));
        chk("idle_rdata", 64'(o_rdata), 64'(exp_rdata));
        slave_noise();
    endtask

    initial begin
        reset     = 1'b1;
        req_read  = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        fixed_m   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0; op_rd[i] = 1'b0; m_addr[i] = '0; m_data[i] = '0;
        end
        slave_quiet();

        // Phase 1: round-robin instance.
        sel     = 1'b0;
        fixed_m = 1'b0;
        do_reset();

        // Single read, ack 3 cycles after the strobe rises.
        set_req(0, 0, 18'o001000, '0);
        do_round('0, 0, 0, 3, 1'b1, 36'o123456701234);
        chk("single_read_rdata", 64'(o_rdata), 64'(36'o123456701234));

        // Page fail together with read ack: pf wins, rdata untouched.
        set_req(1, 0, addr_t'($urandom()), '0);
        do_round('0, 0, 2, 1, 1'b0, '0);
        chk("pf_keeps_rdata", 64'(o_rdata), 64'(36'o123456701234));

        // Timeout, then a normal request straight after.
        set_req(2, 1, addr_t'($urandom()), rand_word());
        do_round('0, 0, 3, 0, 1'b0, '0);
        set_req(0, 1, addr_t'($urandom()), rand_word());
        do_round('0, 0, 0, 0, 1'b0, '0);

        // Contention: ports 0 and 1 write continuously, one-cycle slave.
        for (int i = 0; i < 8; i++) begin
            for (int p = 0; p < 2; p++)
                if (!pend[p]) set_req(p, 1, addr_t'($urandom()), rand_word());
            do_round('0, 0, 0, 1, 1'b0, '0);
        end

        for (int i = 0; i < 120; i++) do_round('1, 50, -1, -1, 1'b0, '0);

        // Reset in the second WAIT cycle.
        for (int i = 0; i < NREQ; i++) drop_req(i);
        set_req(2, 0, addr_t'($urandom()), '0);
        slave_quiet();
        @(posedge clk);
        @(negedge clk);
        chk("rstwait_grant", 64'(o_gid), 64'(2));
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        drop_req(2);
        @(posedge clk);
        @(negedge clk);
        chk("rstwait_strobes", 64'({o_mrd, o_mwr}), 64'(0));
        chk("rstwait_busy", 64'(o_busy), 64'(0));
        chk("rstwait_grant0", 64'(o_gid), 64'(0));
        chk("rstwait_pulses", 64'({o_ack, o_pf, o_nxm}), 64'(0));
        reset         = 1'b0;
        ptr_m         = 0;
        exp_rdata     = '0;
        mem_read_ack  = 1'b1;
        mem_write_ack = 1'b1;
        mem_read_data = rand_word();
        @(posedge clk);
        @(negedge clk);
        chk("late_ack_pulses", 64'({o_ack, o_pf, o_nxm}), 64'(0));
        chk("late_ack_busy", 64'(o_busy), 64'(0));
        chk("late_ack_rdata", 64'(o_rdata), 64'(0));
        slave_quiet();
        for (int i = 0; i < 20; i++) do_round('1, 60, -1, -1, 1'b0, '0);

        // Phase 2: fixed-priority instance.
        sel     = 1'b1;
        fixed_m = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            for (int p = 0; p < 2; p++)
                if (!pend[p]) set_req(p, 1, addr_t'($urandom()), rand_word());
            do_round('0, 0, 0, 1, 1'b0, '0);
            chk("fp_port0_wins", 64'(o_gid), 64'(0));
        end
        for (int i = 0; i < 80; i++) do_round('1, 50, -1, -1, 1'b0, '0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
